gray_pointer_controller: RTL

- Write-side pointer controller for an asynchronous FIFO; one such block sits in the write clock domain.
- Sequences a binary write pointer, accepts pushes through a valid/ready handshake and drives the RAM write port.
- Publishes a registered Gray-coded copy of the pointer for crossing into the read domain.
- Detects full by comparing against the read pointer, which arrives already synchronized and in Gray code.

---
 rtl/gray_pointer_pkg.sv | 33 +++
 rtl/gray_pointer_controller_if.sv | 39 +++
 rtl/gray_pointer_controller_b2g.sv | 11 +
 rtl/gray_pointer_controller.sv | 84 ++++++++
 4 files changed

// File: rtl/gray_pointer_pkg.sv
// Shared helpers for the async-FIFO pointer blocks: pointer width derivation and
// Gray-code conversions, written on a wide container so any pointer width can use them.
package gray_pointer_pkg;

  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_max_t binary_to_gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray_to_binary(input ptr_max_t gray);
    ptr_max_t bin;
    bin = {PTR_MAX_W{1'b0}};
    for (int i = 0; i < PTR_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

  // Full when the local Gray pointer equals the remote one with its top two bits inverted.
  function automatic logic gray_full_compare(input ptr_max_t local_g, input ptr_max_t remote_g,
                                             input int w);
    ptr_max_t mask;
    mask = ptr_max_t'(2'b11) << (w - 2);
    return (local_g == (remote_g ^ mask));
  endfunction

endpackage

// File: rtl/gray_pointer_controller_if.sv
// Push handshake, RAM write port and pointer-exchange signals of the write-side controller.
// fill_level exists only when GRAY_POINTER_CONTROLLER_FILL_LEVEL_EN is defined.
interface gray_pointer_controller_if
  import gray_pointer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
);
  localparam int PTR_WIDTH = ptr_width(ADDR_WIDTH);

  logic                  push_valid;
  logic                  push_ready;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [PTR_WIDTH-1:0]  remote_gray_sync;
  logic [PTR_WIDTH-1:0]  local_gray;
  logic                  full;
`ifdef GRAY_POINTER_CONTROLLER_FILL_LEVEL_EN
  logic [PTR_WIDTH-1:0]  fill_level;

  modport master (
    output push_valid, remote_gray_sync,
    input  push_ready, write_enable, write_address, local_gray, full, fill_level
  );
  modport slave (
    input  push_valid, remote_gray_sync,
    output push_ready, write_enable, write_address, local_gray, full, fill_level
  );
`else
  modport master (
    output push_valid, remote_gray_sync,
    input  push_ready, write_enable, write_address, local_gray, full
  );
  modport slave (
    input  push_valid, remote_gray_sync,
    output push_ready, write_enable, write_address, local_gray, full
  );
`endif

endinterface

// File: rtl/gray_pointer_controller_b2g.sv
// Purely combinational binary-to-Gray converter of configurable width.
module Binary_to_Gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_pointer_controller.sv
// Write-side pointer controller of an async FIFO: binary pointer, registered Gray copy, full flag.
// Optional registered fill_level output under GRAY_POINTER_CONTROLLER_FILL_LEVEL_EN.
module gray_pointer_controller
  import gray_pointer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input logic                      clock,
  input logic                      clear_n,
  gray_pointer_controller_if.slave bus
);

  localparam int PTR_WIDTH = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] r_ptr;
  logic [PTR_WIDTH-1:0] r_local_gray;
  logic                 r_full;
  logic [PTR_WIDTH-1:0] w_ptr_next;
  logic [PTR_WIDTH-1:0] w_gray_next;
  logic                 w_ready;
  logic                 w_xfer;
  logic                 w_full_next;

  // Ready drops during reset so a held push_valid can never slip a write in.
  assign w_ready           = ~r_full & clear_n;
  assign w_xfer            = bus.push_valid & w_ready;
  assign bus.push_ready    = w_ready;
  assign bus.write_enable  = w_xfer;
  assign bus.write_address = r_ptr[ADDR_WIDTH-1:0];
  assign bus.local_gray    = r_local_gray;
  assign bus.full          = r_full;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_xfer) begin
      w_ptr_next = r_ptr + PTR_ONE;
    end else begin
      w_ptr_next = r_ptr;
    end
  end

  Binary_to_Gray #(.WIDTH(PTR_WIDTH)) u_b2g (
    .i_bin  (w_ptr_next),
    .o_gray (w_gray_next)
  );

  // Compare the post-push pointer so full rises on the edge that fills the last slot.
  assign w_full_next = gray_full_compare(ptr_max_t'(w_gray_next),
                                         ptr_max_t'(bus.remote_gray_sync), PTR_WIDTH);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_ptr        <= {PTR_WIDTH{1'b0}};
      r_local_gray <= {PTR_WIDTH{1'b0}};
      r_full       <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_next;
      r_local_gray <= w_gray_next;
      r_full       <= w_full_next;
    end
  end

`ifdef GRAY_POINTER_CONTROLLER_FILL_LEVEL_EN
  ptr_max_t             w_remote_bin_wide;
  ptr_max_t             w_fill_wide;
  logic                 w_unused_fill_hi;
  logic [PTR_WIDTH-1:0] r_fill_level;

  assign w_remote_bin_wide = gray_to_binary(ptr_max_t'(bus.remote_gray_sync));
  assign w_fill_wide       = ptr_max_t'(r_ptr) - w_remote_bin_wide;
  assign w_unused_fill_hi  = ^w_fill_wide[PTR_MAX_W-1:PTR_WIDTH];
  assign bus.fill_level    = r_fill_level;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_fill_level <= {PTR_WIDTH{1'b0}};
    end else begin
      r_fill_level <= w_fill_wide[PTR_WIDTH-1:0];
    end
  end
`endif

endmodule
